hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Stall/flush controller for the five-stage pipeline: decides each cycle whether the program counter and the F/D register hold and whether a bubble enters E. It detects read-after-write hazards that forwarding cannot cover (Tuse/Tnew rule). It also tracks the multi-cycle multiply/divide unit with an internal busy counter. `pc_stall` drives the PC register's `PCstall` input directly.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles after a mult/multu issues in E.
- `DIV_CYCLES`, 10: busy cycles after a div/divu issues in E.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `d_rs`, `d_rt`  in  5 each  source registers of the instruction in D.
- `d_rs_tuse`, `d_rt_tuse`  in  2 each  cycles until the operand is needed; 3 = operand unused.
- `d_is_md`  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- `e_wreg`, `m_wreg`  in  5 each  destination register of the E/M instruction; 0 = none.
- `e_tnew`, `m_tnew`  in  2 each  cycles until the E/M result is forwardable, range 0..2.
- `e_md_start`  in  1  mult/div is in E this cycle and is not a bubble.
- `e_md_is_div`  in  1  qualifies `e_md_start`: 1 = div/divu, 0 = mult/multu.
- `pc_stall`  out  1  hold PC.
- `d_en`  out  1  F/D register enable; always equals `~pc_stall`.
- `e_flush`  out  1  load a bubble into D/E; always equals `pc_stall`.
- `md_busy`  out  1  multiply/divide unit busy.
- `stall_cycles`  out  32  count of stalled cycles since reset; saturating.

## Operation
- Data hazard for an operand `r` with Tuse `t` exists when `r != 0` and either of these holds:
  - `r == e_wreg` and `e_tnew > t`;
  - `r == m_wreg` and `m_tnew > t`.
- `data_stall` is the OR of the rs and rt hazards. A Tuse of 3 never stalls.
- `md_stall = d_is_md & (md_busy | e_md_start)`.
- `pc_stall = data_stall | md_stall`. This path is purely combinational from the current inputs and `md_busy`.
- The busy counter `md_cnt` is 4 bits wide; the maximum parameter value is 15.
  - If `e_md_start` and `md_cnt == 0`: load `DIV_CYCLES` when `e_md_is_div` is 1, otherwise `MULT_CYCLES`.
  - Else if `md_cnt != 0`: decrement by 1.
  - `e_md_start` while `md_cnt != 0` is ignored: no reload, and decrementing continues. This is unreachable in a legal pipeline because `md_stall` blocks the issue.
- `md_busy = (md_cnt != 0)`. It is taken from the register only, not from `e_md_start`.
- `stall_cycles` increments at each rising edge where `pc_stall == 1`. It holds at 32'hFFFFFFFF and does not wrap.
- `e_flush` must not be used to suppress `e_md_start` in the same cycle; the pipeline registers handle that.

## Timing
- Reset is asynchronous:
  - `md_cnt` goes to 0 and `stall_cycles` goes to 0 immediately on assertion;
  - `md_busy` reads 0 during reset;
  - `pc_stall`, `d_en` and `e_flush` follow the combinational equations, with `md_busy` at 0.
- Reset asserted mid-operation aborts any busy countdown; no stall persists after release unless the inputs create a new one.
- `e_md_start` high at edge k gives `md_busy` = 1 for exactly N cycles (k+1 .. k+N), where N = `MULT_CYCLES` or `DIV_CYCLES`; `md_busy` is 0 from k+N+1.
- A stall decision appears in the same cycle as its inputs and takes effect at the next edge: the PC and F/D hold, and E receives a bubble.
- A data stall and an md stall occurring together count as one stalled cycle.

## Test plan
- Load-use: `d_rs`=5, `d_rs_tuse`=1, `e_wreg`=5, `e_tnew`=2 -> `pc_stall`=1, `d_en`=0, `e_flush`=1. Next cycle, with `m_wreg`=5 and `m_tnew`=1 -> `pc_stall`=0. `stall_cycles` reads 1.
- Register 0 and unused operand:
  - `d_rs`=0 matching `e_wreg`=0 with `e_tnew`=2 -> no stall;
  - `d_rt`=7, `d_rt_tuse`=3, `e_wreg`=7, `e_tnew`=2 -> no stall.
- Multiply: pulse `e_md_start`=1, `e_md_is_div`=0 for one cycle -> `md_busy` high for exactly 5 cycles. Hold `d_is_md`=1 throughout -> `pc_stall` high on the start cycle plus those 5 cycles (6 total), then low.
- Divide with no md consumer: pulse `e_md_is_div`=1 -> `md_busy` high for 10 cycles. With `d_is_md`=0 and no data hazard -> `pc_stall` stays 0.
- Reset mid-divide: assert `reset` asynchronously (between edges) 4 cycles into a divide -> `md_busy`=0 and `stall_cycles`=0 immediately. After release -> no stall with idle inputs.
- Saturation: force `pc_stall` continuously from a preloaded `stall_cycles`=32'hFFFFFFFE (bench backdoor) -> reads FFFFFFFF after one edge and stays FFFFFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Stall/flush control for the five-stage pipeline: Tuse/Tnew RAW hazards plus a mult/div busy countdown.
// Stall outputs are combinational from the current inputs and md_busy; md_busy and stall_cycles are registered.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_rs_tuse,
    input  logic [1:0]  d_rt_tuse,
    input  logic        d_is_md,
    input  logic [4:0]  e_wreg,
    input  logic [4:0]  m_wreg,
    input  logic [1:0]  e_tnew,
    input  logic [1:0]  m_tnew,
    input  logic        e_md_start,
    input  logic        e_md_is_div,
    output logic        pc_stall,
    output logic        d_en,
    output logic        e_flush,
    output logic        md_busy,
    output logic [31:0] stall_cycles
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [3:0] md_cnt;
    logic       rs_hazard;
    logic       rt_hazard;
    logic       data_stall;
    logic       md_stall;

    // An operand stalls only if a producer will still be short of a forwardable result when it is needed.
    function automatic logic operand_hazard(
        input logic [4:0] r,
        input logic [1:0] tuse,
        input logic [4:0] ew,
        input logic [1:0] et,
        input logic [4:0] mw,
        input logic [1:0] mt
    );
        return (r != 5'd0) && (((r == ew) && (et > tuse)) || ((r == mw) && (mt > tuse)));
    endfunction

    always_comb begin
        rs_hazard  = operand_hazard(d_rs, d_rs_tuse, e_wreg, e_tnew, m_wreg, m_tnew);
        rt_hazard  = operand_hazard(d_rt, d_rt_tuse, e_wreg, e_tnew, m_wreg, m_tnew);
        data_stall = rs_hazard | rt_hazard;
        md_stall   = d_is_md & (md_busy | e_md_start);
        pc_stall   = data_stall | md_stall;
        d_en       = ~pc_stall;
        e_flush    = pc_stall;
    end

    assign md_busy = (md_cnt != 4'd0);

    // A start while already counting is ignored; the stall logic keeps that from happening.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt <= 4'd0;
        end else if (e_md_start && (md_cnt == 4'd0)) begin
            md_cnt <= e_md_is_div ? DIV_LOAD : MULT_LOAD;
        end else if (md_cnt != 4'd0) begin
            md_cnt <= md_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= 32'd0;
        end else if (pc_stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: rule-level model checked every cycle plus hand-computed directed expectations.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  d_rs, d_rt, e_wreg, m_wreg;
    logic [1:0]  d_rs_tuse, d_rt_tuse, e_tnew, m_tnew;
    logic        d_is_md, e_md_start, e_md_is_div;
    logic        pc_stall, d_en, e_flush, md_busy;
    logic [31:0] stall_cycles;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
        .d_is_md(d_is_md), .e_wreg(e_wreg), .m_wreg(m_wreg),
        .e_tnew(e_tnew), .m_tnew(m_tnew),
        .e_md_start(e_md_start), .e_md_is_div(e_md_is_div),
        .pc_stall(pc_stall), .d_en(d_en), .e_flush(e_flush),
        .md_busy(md_busy), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Model: the unit is busy while the edge count is below the edge at which its countdown ends.
    longint unsigned edges    = 0;
    longint unsigned busy_end = 0;
    logic [31:0]     m_cnt    = 32'd0;

    function automatic logic m_busy();
        return edges < busy_end;
    endfunction

    function automatic logic op_hz(input logic [4:0] r, input logic [1:0] t);
        if (r == 5'd0) return 1'b0;
        return ((r == e_wreg) && (int'(e_tnew) > int'(t))) || ((r == m_wreg) && (int'(m_tnew) > int'(t)));
    endfunction

    function automatic logic exp_stall();
        return op_hz(d_rs, d_rs_tuse) || op_hz(d_rt, d_rt_tuse) || (d_is_md && (m_busy() || e_md_start));
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_end = 0;
            m_cnt    = 32'd0;
        end else begin
            logic st;
            logic b;
            st = exp_stall();
            b  = m_busy();
            edges++;
            if (e_md_start && !b) busy_end = edges + (e_md_is_div ? 10 : 5);
            if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_pc_stall", 32'(pc_stall), 32'(exp_stall()));
            chk("model_d_en",     32'(d_en),     32'(!exp_stall()));
            chk("model_e_flush",  32'(e_flush),  32'(exp_stall()));
            chk("model_md_busy",  32'(md_busy),  32'(m_busy()));
            chk("model_stall_cycles", stall_cycles, m_cnt);
        end
    end

    task automatic idle();
        d_rs = 5'd0; d_rt = 5'd0; d_rs_tuse = 2'd3; d_rt_tuse = 2'd3;
        d_is_md = 1'b0; e_wreg = 5'd0; m_wreg = 5'd0; e_tnew = 2'd0; m_tnew = 2'd0;
        e_md_start = 1'b0; e_md_is_div = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] base;

    initial begin
        idle();
        #12;
        chk("reset_md_busy", 32'(md_busy), 32'd0);
        chk("reset_stall_cycles", stall_cycles, 32'd0);
        chk("reset_pc_stall", 32'(pc_stall), 32'd0);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        next();

        // Load-use: E producer not ready for a Tuse=1 operand.
        d_rs = 5'd5; d_rs_tuse = 2'd1; e_wreg = 5'd5; e_tnew = 2'd2;
        @(negedge clk);
        chk("loaduse_pc_stall", 32'(pc_stall), 32'd1);
        chk("loaduse_d_en", 32'(d_en), 32'd0);
        chk("loaduse_e_flush", 32'(e_flush), 32'd1);
        next();
        e_wreg = 5'd0; e_tnew = 2'd0; m_wreg = 5'd5; m_tnew = 2'd1;
        @(negedge clk);
        chk("loaduse_resolved", 32'(pc_stall), 32'd0);
        chk("loaduse_count", stall_cycles, 32'd1);
        next();

        // Register 0 and unused operand never stall.
        idle();
        d_rs = 5'd0; d_rs_tuse = 2'd0; e_wreg = 5'd0; e_tnew = 2'd2;
        @(negedge clk);
        chk("r0_no_stall", 32'(pc_stall), 32'd0);
        next();
        idle();
        d_rt = 5'd7; d_rt_tuse = 2'd3; e_wreg = 5'd7; e_tnew = 2'd2;
        @(negedge clk);
        chk("tuse3_no_stall", 32'(pc_stall), 32'd0);
        next();

        // Multiply with an md consumer held in D: 1 start cycle + 5 busy cycles stalled.
        idle();
        d_is_md = 1'b1; e_md_start = 1'b1;
        @(negedge clk);
        base = stall_cycles;
        chk("mult_start_stall", 32'(pc_stall), 32'd1);
        chk("mult_start_busy", 32'(md_busy), 32'd0);
        next();
        e_md_start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("mult_busy", 32'(md_busy), 32'd1);
            chk("mult_stall", 32'(pc_stall), 32'd1);
            next();
        end
        @(negedge clk);
        chk("mult_done_busy", 32'(md_busy), 32'd0);
        chk("mult_done_stall", 32'(pc_stall), 32'd0);
        chk("mult_stall_count", stall_cycles - base, 32'd6);
        next();

        // Divide with no md consumer: busy 10 cycles, never stalls.
        idle();
        e_md_start = 1'b1; e_md_is_div = 1'b1;
        @(negedge clk);
        chk("div_start_stall", 32'(pc_stall), 32'd0);
        next();
        idle();
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            chk("div_busy", 32'(md_busy), 32'd1);
            chk("div_stall", 32'(pc_stall), 32'd0);
            next();
        end
        @(negedge clk);
        chk("div_done_busy", 32'(md_busy), 32'd0);
        next();

        // Reset asserted between edges four cycles into a divide.
        e_md_start = 1'b1; e_md_is_div = 1'b1;
        next();
        idle();
        repeat (3) next();
        #2 reset = 1'b1;
        #1;
        chk("arst_md_busy", 32'(md_busy), 32'd0);
        chk("arst_stall_cycles", stall_cycles, 32'd0);
        chk("arst_pc_stall", 32'(pc_stall), 32'd0);
        #3 reset = 1'b0;
        next();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_reset_busy", 32'(md_busy), 32'd0);
            chk("post_reset_stall", 32'(pc_stall), 32'd0);
            next();
        end

        // Saturation from a preloaded count with a persistent data hazard.
        d_rs = 5'd5; d_rs_tuse = 2'd0; e_wreg = 5'd5; e_tnew = 2'd1;
        dut.stall_cycles = 32'hFFFF_FFFE;
        m_cnt = 32'hFFFF_FFFE;
        @(negedge clk);
        chk("sat_preload", stall_cycles, 32'hFFFF_FFFE);
        for (int i = 0; i < 4; i++) begin
            next();
            @(negedge clk);
            chk("sat_hold", stall_cycles, 32'hFFFF_FFFF);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
